// File: rtl/aes_key_schedule.sv
// AES-128/256 round-key generator: emits rk0..rkNr one per valid/ready handshake,
// computing each new key from the two previous ones through a registered 4-byte S-box.
module aes_key_schedule #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic                key_valid,
   output logic                key_ready,
   output logic [127:0]        rk_out,
   output logic [3:0]          rk_idx,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic                rk_last,
   output logic                busy
);

   localparam bit       WIDE = (KEY_BITS == 256);
   localparam logic [3:0] NR = WIDE ? 4'd14 : 4'd10;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;

   state_t        state_q, state_d;
   logic [127:0]  prev1_q, prev1_d;   // round key j (the one on rk_out)
   logic [127:0]  prev2_q, prev2_d;   // round key j-1
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [31:0]   sub_q;
   logic [31:0]   sub_in;
   logic [31:0]   t_word;
   logic [127:0]  next_key;
   logic          rot_next;

   // The next index is even (RotWord + Rcon step) whenever the current one is odd;
   // AES-128 takes that step for every key.
   assign rot_next = !WIDE || idx_q[0];

   always_comb begin
      sub_in = rot_next ? {prev1_q[23:0], prev1_q[31:24]} : prev1_q[31:0];
      t_word = rot_next ? (sub_q ^ {rcon_q, 24'h0}) : sub_q;
      next_key[127:96] = prev2_q[127:96] ^ t_word;
      next_key[95:64]  = next_key[127:96] ^ prev2_q[95:64];
      next_key[63:32]  = next_key[95:64]  ^ prev2_q[63:32];
      next_key[31:0]   = next_key[63:32]  ^ prev2_q[31:0];
   end

   // NOTE: pipeline register for the S-box lookup needs no reset; it is always
   // reloaded in EMIT before SUB consumes it.
   always_ff @(posedge clk) begin
      sub_q <= {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
   end

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      prev1_d = prev1_q;
      prev2_d = prev2_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      case (state_q)
         IDLE: begin
            if (key_valid) begin
               state_d = EMIT;
               idx_d   = 4'd0;
               rcon_d  = 8'h01;
               prev1_d = key_in[KEY_BITS-1 -: 128];
               // For AES-256 this parks the second key half until rk1 is emitted.
               prev2_d = key_in[127:0];
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (idx_q == NR) begin
                  state_d = IDLE;
               end else if (WIDE && idx_q == 4'd0) begin
                  idx_d   = 4'd1;
                  prev1_d = prev2_q;
                  prev2_d = prev1_q;
               end else begin
                  state_d = SUB;
               end
            end
         end
         SUB: begin
            state_d = EMIT;
            idx_d   = idx_q + 4'd1;
            prev1_d = next_key;
            prev2_d = WIDE ? prev1_q : next_key;
            if (rot_next) begin
               rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         prev1_q <= '0;
         prev2_q <= '0;
         idx_q   <= '0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         prev1_q <= prev1_d;
         prev2_q <= prev2_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
      end
   end

   assign key_ready = (state_q == IDLE) && !reset;
   assign busy      = (state_q != IDLE);
   assign rk_valid  = (state_q == EMIT);
   assign rk_out    = prev1_q;
   assign rk_idx    = idx_q;
   assign rk_last   = rk_valid && (idx_q == NR);

endmodule
